// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path:
// arbiter state encoding, byte width and default timeouts.
package uart_pkg;

    localparam int UART_BYTE_W      = 8;
    localparam int BUSY_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus transmitter strobe/busy bundle
// between byte sources, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic [UART_BYTE_W-1:0]         tx_data;
    logic                           tx_wr_en;
    logic                           tx_busy;

    // Sources and transmitter side
    modport master (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_data,
        input  tx_wr_en
    );

    // Arbiter side
    modport slave (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_data,
        output tx_wr_en
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last+1
// upward modulo N and returns a one-hot grant and its index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 2,
    localparam int IW = idx_w(N)
)(
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int p;
        logic found;
        grant = '0;
        idx   = last;
        found = 1'b0;
        p     = 0;
        for (int k = 1; k <= N; k++) begin
            p = (int'(last) + k) % N;
            if (!found && valid[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources,
// issuing a write strobe and tracking tx_busy to completion.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    parameter int CNT_W        = 16,
    localparam int IW          = idx_w(NUM_REQ)
)(
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [IW-1:0]    grant_id,
    output logic             err_timeout,
    output logic [CNT_W-1:0] bytes_sent
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    arb_state_t             state;
    logic [TO_W-1:0]        to_cnt;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   tx_wr_en_q;

    logic [NUM_REQ-1:0]     win_oh;
    logic [IW-1:0]          win_idx;
    logic                   win_any;
    logic                   arb_en;
    logic                   accept;
    logic [UART_BYTE_W-1:0] win_byte;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .valid(bus.req_valid),
        .last (grant_id),
        .grant(win_oh),
        .idx  (win_idx),
        .any  (win_any)
    );

    assign arb_en        = (state == S_IDLE) && !bus.tx_busy;
    assign accept        = arb_en && win_any;
    assign bus.req_ready = arb_en ? win_oh : '0;
    assign win_byte      =
        bus.req_data[UART_BYTE_W*win_idx +: UART_BYTE_W];

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr_en = tx_wr_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx_data_q   <= '0;
            tx_wr_en_q  <= 1'b0;
            grant_id    <= IW'(NUM_REQ - 1);
            err_timeout <= 1'b0;
            bytes_sent  <= '0;
            to_cnt      <= '0;
        end else begin
            tx_wr_en_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        tx_data_q  <= win_byte;
                        grant_id   <= win_idx;
                        tx_wr_en_q <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        // Transmitter never took the byte: drop it.
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        bytes_sent <= bytes_sent + 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: handshake timing,
// round robin, busy blocking, timeout, reset and count wrap.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int BTO  = 16;
    localparam int CW   = 4;

    logic          clk;
    logic          rst;
    logic [0:0]    grant_id;
    logic          err_timeout;
    logic [CW-1:0] bytes_sent;

    int n_checks;
    int n_fails;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .BUSY_TIMEOUT(BTO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant_id   (grant_id),
        .err_timeout(err_timeout),
        .bytes_sent (bytes_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // From the strobe cycle: busy rises, holds, falls.
    task automatic finish_frame();
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        while (!bus.tx_wr_en && n < 20) begin
            tick();
            n++;
        end
        check("strobe_seen", 32'(bus.tx_wr_en), 32'd1);
    endtask

    task automatic serve(input logic [7:0] eb,
                         input logic [0:0] eg);
        wait_strobe();
        check("tx_data", 32'(bus.tx_data), 32'(eb));
        check("grant_id", 32'(grant_id), 32'(eg));
        finish_frame();
    endtask

    initial begin
        logic [7:0] rr_b [4];
        int n;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_wr_en", 32'(bus.tx_wr_en), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd1);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_bytes", 32'(bytes_sent), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);

        // Single requester
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h00A5;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 2'b00;
        check("single_wr", 32'(bus.tx_wr_en), 32'd1);
        check("single_data", 32'(bus.tx_data), 32'hA5);
        check("single_gid", 32'(grant_id), 32'd0);
        check("single_ready_off", 32'(bus.req_ready), 32'd0);
        tick();
        check("single_wr_one", 32'(bus.tx_wr_en), 32'd0);
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
        check("single_bytes", 32'(bytes_sent), 32'd1);

        // Round robin from a fresh reset
        do_reset();
        rr_b = '{8'h11, 8'h22, 8'h11, 8'h22};
        bus.req_valid = 2'b11;
        bus.req_data  = 16'h2211;
        for (int k = 0; k < 4; k++)
            serve(rr_b[k], 1'(k % 2));
        bus.req_valid = 2'b00;
        check("rr_bytes", 32'(bytes_sent), 32'd4);

        // Busy blocking
        bus.tx_busy   = 1'b1;
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h3300;
        #1;
        check("blk_ready", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("blk_wr", 32'(bus.tx_wr_en), 32'd0);
        end
        bus.tx_busy = 1'b0;
        #1;
        check("blk_release_ready", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b00;
        check("blk_wr_after", 32'(bus.tx_wr_en), 32'd1);
        check("blk_data", 32'(bus.tx_data), 32'h33);
        check("blk_gid", 32'(grant_id), 32'd1);
        finish_frame();
        check("blk_bytes", 32'(bytes_sent), 32'd5);

        // Timeout: transmitter never raises busy
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h0044;
        wait_strobe();
        bus.req_valid = 2'b00;
        check("to_data", 32'(bus.tx_data), 32'h44);
        tick();
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'(BTO));
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_bytes", 32'(bytes_sent), 32'd5);
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h5500;
        #1;
        check("to_idle_ready", 32'(bus.req_ready), 32'd2);
        serve(8'h55, 1'b1);
        bus.req_valid = 2'b00;
        check("to_next_bytes", 32'(bytes_sent), 32'd6);
        check("to_sticky", 32'(err_timeout), 32'd1);

        // Reset in the middle of a frame
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h0066;
        wait_strobe();
        bus.req_valid = 2'b00;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tx_busy = 1'b0;
        check("mid_wr", 32'(bus.tx_wr_en), 32'd0);
        check("mid_bytes", 32'(bytes_sent), 32'd0);
        check("mid_err", 32'(err_timeout), 32'd0);
        check("mid_gid", 32'(grant_id), 32'd1);
        bus.req_valid = 2'b01;
        #1;
        check("mid_idle_ready", 32'(bus.req_ready), 32'd1);

        // Counter wrap with a 4-bit count
        for (int i = 1; i <= 16; i++) begin
            bus.req_data = 16'(i);
            serve(8'(i), 1'b0);
            if (i == 15)
                check("wrap_15", 32'(bytes_sent), 32'd15);
        end
        bus.req_valid = 2'b00;
        check("wrap_0", 32'(bytes_sent), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
